// File: rtl/shake_arbiter_if.sv
// Handshake bundle between shake_arbiter, its two requesters and the keccak_top core.
// master = arbiter view, slave = requesters/core view.
interface shake_arbiter_if #(
   parameter int W = 32
);
   logic         r0_din_valid;
   logic         r0_din_ready;
   logic [W-1:0] r0_din;
   logic         r0_dout_valid;
   logic         r0_dout_ready;
   logic [W-1:0] r0_dout;
   logic         r0_force_done;

   logic         r1_din_valid;
   logic         r1_din_ready;
   logic [W-1:0] r1_din;
   logic         r1_dout_valid;
   logic         r1_dout_ready;
   logic [W-1:0] r1_dout;
   logic         r1_force_done;

   logic         din_valid_shake;
   logic         din_ready_shake;
   logic [W-1:0] din_shake;
   logic         dout_valid_shake;
   logic         dout_ready_shake;
   logic [W-1:0] dout_shake;
   logic         force_done_shake;

   logic [1:0]   grant;
   logic         busy;

   modport master (
      input  r0_din_valid, r0_din, r0_dout_ready, r0_force_done,
      input  r1_din_valid, r1_din, r1_dout_ready, r1_force_done,
      input  din_ready_shake, dout_valid_shake, dout_shake,
      output r0_din_ready, r0_dout_valid, r0_dout,
      output r1_din_ready, r1_dout_valid, r1_dout,
      output din_valid_shake, din_shake, dout_ready_shake, force_done_shake,
      output grant, busy
   );

   modport slave (
      output r0_din_valid, r0_din, r0_dout_ready, r0_force_done,
      output r1_din_valid, r1_din, r1_dout_ready, r1_force_done,
      output din_ready_shake, dout_valid_shake, dout_shake,
      input  r0_din_ready, r0_dout_valid, r0_dout,
      input  r1_din_ready, r1_dout_valid, r1_dout,
      input  din_valid_shake, din_shake, dout_ready_shake, force_done_shake,
      input  grant, busy
   );
endinterface

// File: rtl/shake_arbiter.sv
// Session-level round-robin arbiter sharing one keccak_top core between two requesters.
// Optional SHAKE_ARB_PROFILE_EN adds saturating per-requester session counters.
module shake_arbiter #(
   parameter int W            = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   shake_arbiter_if.master   sh
`ifdef SHAKE_ARB_PROFILE_EN
   ,
   output logic [15:0]       sess_cnt0,
   output logic [15:0]       sess_cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, G0, G1, FLUSH} state_t;

   state_t     state, state_nxt;
   logic [3:0] flush_cnt, flush_cnt_nxt;
   logic       last_grant, last_grant_nxt;   // 0: r0 owned last session, 1: r1

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         flush_cnt  <= '0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         flush_cnt  <= flush_cnt_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      flush_cnt_nxt  = flush_cnt;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            // On a tie the requester that did not own the previous session wins.
            if (sh.r0_din_valid && sh.r1_din_valid) begin
               state_nxt      = last_grant ? G0 : G1;
               last_grant_nxt = ~last_grant;
            end else if (sh.r0_din_valid) begin
               state_nxt      = G0;
               last_grant_nxt = 1'b0;
            end else if (sh.r1_din_valid) begin
               state_nxt      = G1;
               last_grant_nxt = 1'b1;
            end
         end
         G0: begin
            if (sh.r0_force_done) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
            end
         end
         G1: begin
            if (sh.r1_force_done) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (flush_cnt == '0) state_nxt = IDLE;
            else                 flush_cnt_nxt = flush_cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sh.din_valid_shake  = 1'b0;
      sh.din_shake        = '0;
      sh.dout_ready_shake = 1'b0;
      sh.force_done_shake = 1'b0;
      sh.r0_din_ready     = 1'b0;
      sh.r0_dout_valid    = 1'b0;
      sh.r0_dout          = '0;
      sh.r1_din_ready     = 1'b0;
      sh.r1_dout_valid    = 1'b0;
      sh.r1_dout          = '0;
      sh.grant            = 2'b00;
      sh.busy             = (state != IDLE);
      case (state)
         G0: begin
            sh.grant            = 2'b01;
            sh.din_valid_shake  = sh.r0_din_valid;
            sh.din_shake        = sh.r0_din;
            sh.dout_ready_shake = sh.r0_dout_ready;
            sh.force_done_shake = sh.r0_force_done;
            sh.r0_din_ready     = sh.din_ready_shake;
            sh.r0_dout_valid    = sh.dout_valid_shake;
            sh.r0_dout          = sh.dout_shake;
         end
         G1: begin
            sh.grant            = 2'b10;
            sh.din_valid_shake  = sh.r1_din_valid;
            sh.din_shake        = sh.r1_din;
            sh.dout_ready_shake = sh.r1_dout_ready;
            sh.force_done_shake = sh.r1_force_done;
            sh.r1_din_ready     = sh.din_ready_shake;
            sh.r1_dout_valid    = sh.dout_valid_shake;
            sh.r1_dout          = sh.dout_shake;
         end
         default: ;
      endcase
   end

`ifdef SHAKE_ARB_PROFILE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sess_cnt0 <= '0;
         sess_cnt1 <= '0;
      end else begin
         if (state == G0 && sh.r0_force_done && sess_cnt0 != '1)
            sess_cnt0 <= sess_cnt0 + 16'd1;
         if (state == G1 && sh.r1_force_done && sess_cnt1 != '1)
            sess_cnt1 <= sess_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_shake_arbiter.sv
// Randomized + directed bench for shake_arbiter against a session-level reference model.
module tb_shake_arbiter;
   localparam int W  = 32;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   shake_arbiter_if #(.W(W)) sh();

`ifdef SHAKE_ARB_PROFILE_EN
   logic [15:0] sess_cnt0, sess_cnt1;
`endif

   shake_arbiter #(.W(W), .FLUSH_CYCLES(FC)) dut (
      .clk(clk),
      .rst(rst),
      .sh(sh)
`ifdef SHAKE_ARB_PROFILE_EN
      ,
      .sess_cnt0(sess_cnt0),
      .sess_cnt1(sess_cnt1)
`endif
   );

   // stimulus
   logic         v0, v1, fd0, fd1, dr0, dr1, cdr, cdv;
   logic [W-1:0] d0, d1, cd;

   // reference model: session owner (-1 none), remaining flush cycles, last owner
   int owner, gap, last;
   int m_sess0, m_sess1;
   int starts[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic apply();
      sh.r0_din_valid     = v0;
      sh.r0_din           = d0;
      sh.r0_dout_ready    = dr0;
      sh.r0_force_done    = fd0;
      sh.r1_din_valid     = v1;
      sh.r1_din           = d1;
      sh.r1_dout_ready    = dr1;
      sh.r1_force_done    = fd1;
      sh.din_ready_shake  = cdr;
      sh.dout_valid_shake = cdv;
      sh.dout_shake       = cd;
   endtask

   task automatic stim_idle();
      v0 = 0; v1 = 0; fd0 = 0; fd1 = 0; dr0 = 0; dr1 = 0; cdr = 0; cdv = 0;
      d0 = '0; d1 = '0; cd = '0;
   endtask

   task automatic model_reset();
      owner = -1; gap = 0; last = 1;
      m_sess0 = 0; m_sess1 = 0;
   endtask

   task automatic model_step();
      if (owner == -1 && gap == 0) begin
         if (v0 && v1)  owner = (last == 0) ? 1 : 0;
         else if (v0)   owner = 0;
         else if (v1)   owner = 1;
         if (owner != -1) begin
            last = owner;
            starts.push_back(owner);
         end
      end else if (owner != -1) begin
         if ((owner == 0 && fd0) || (owner == 1 && fd1)) begin
            if (owner == 0) m_sess0 = (m_sess0 < 65535) ? m_sess0 + 1 : m_sess0;
            else            m_sess1 = (m_sess1 < 65535) ? m_sess1 + 1 : m_sess1;
            owner = -1;
            gap   = FC;
         end
      end else begin
         gap--;
      end
   endtask

   task automatic check_outputs();
      logic [1:0]   e_grant;
      logic [W-1:0] e_din, e_dout0, e_dout1;
      logic         e_dv, e_drs, e_fds, e_r0r, e_r0v, e_r1r, e_r1v;
      e_grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      e_dv  = (owner == 0) ? v0  : (owner == 1) ? v1  : 1'b0;
      e_din = (owner == 0) ? d0  : (owner == 1) ? d1  : '0;
      e_drs = (owner == 0) ? dr0 : (owner == 1) ? dr1 : 1'b0;
      e_fds = (owner == 0) ? fd0 : (owner == 1) ? fd1 : 1'b0;
      e_r0r = (owner == 0) && cdr;
      e_r0v = (owner == 0) && cdv;
      e_r1r = (owner == 1) && cdr;
      e_r1v = (owner == 1) && cdv;
      e_dout0 = (owner == 0) ? cd : '0;
      e_dout1 = (owner == 1) ? cd : '0;
      check("grant",            32'(sh.grant),            32'(e_grant));
      check("busy",             32'(sh.busy),             32'(owner != -1 || gap > 0));
      check("din_valid_shake",  32'(sh.din_valid_shake),  32'(e_dv));
      check("din_shake",        sh.din_shake,             e_din);
      check("dout_ready_shake", 32'(sh.dout_ready_shake), 32'(e_drs));
      check("force_done_shake", 32'(sh.force_done_shake), 32'(e_fds));
      check("r0_din_ready",     32'(sh.r0_din_ready),     32'(e_r0r));
      check("r0_dout_valid",    32'(sh.r0_dout_valid),    32'(e_r0v));
      check("r0_dout",          sh.r0_dout,               e_dout0);
      check("r1_din_ready",     32'(sh.r1_din_ready),     32'(e_r1r));
      check("r1_dout_valid",    32'(sh.r1_dout_valid),    32'(e_r1v));
      check("r1_dout",          sh.r1_dout,               e_dout1);
   endtask

   task automatic check_profile();
`ifdef SHAKE_ARB_PROFILE_EN
      check("sess_cnt0", 32'(sess_cnt0), 32'(m_sess0));
      check("sess_cnt1", 32'(sess_cnt1), 32'(m_sess1));
`endif
   endtask

   // one clock: drive at posedge+1, check at negedge, advance model at posedge
   task automatic cycle();
      apply();
      #4;
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      stim_idle();
      apply();
      rst = 1'b1;
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_owner(input int who, input string tag);
      int k = 0;
      while (owner != who && k < 20) begin
         cycle();
         k++;
      end
      check(tag, 32'(owner), 32'(who));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_idle();
      model_reset();
      apply();
      @(posedge clk);
      #1;
      do_reset();

      // r0 alone, two words, core always ready
      cdr = 1;
      v0 = 1; d0 = 32'hA5A5A5A5;
      cycle();                                  // IDLE: request sampled
      check("r0_grant_latency", 32'(sh.grant), 32'h1);
      cycle();                                  // G0: word 0 transfers
      d0 = 32'h00000001;
      cycle();                                  // G0: word 1 transfers
      v0 = 0; fd0 = 1;
      cycle();
      fd0 = 0;
      repeat (4) cycle();
      check_profile();

      // contention from reset, 4 sessions of continuous dual request
      do_reset();
      starts.delete();
      cdr = 1; v0 = 1; v1 = 1;
      for (int s = 0; s < 4; s++) begin
         int o;
         wait_owner(s % 2, "rr_wait_grant");
         o = owner;
         repeat (2) begin
            d0 = $urandom; d1 = $urandom;
            cycle();
         end
         if (o == 0) fd0 = 1; else fd1 = 1;
         cycle();
         fd0 = 0; fd1 = 0;
      end
      for (int i = 0; i < 4; i++)
         check("rr_order", (i < starts.size()) ? 32'(starts[i]) : 32'hFFFFFFFF, 32'(i % 2));
      check_profile();

      // output backpressure in G1
      do_reset();
      v0 = 0; v1 = 1;
      wait_owner(1, "bp_wait_g1");
      for (int i = 0; i < 8; i++) begin
         dr1 = i[0];
         cdv = 1;
         cd  = $urandom;
         cycle();
      end
      fd1 = 1;
      cycle();
      fd1 = 0; cdv = 0;
      repeat (3) cycle();

      // asynchronous reset mid-session, r1 pending
      do_reset();
      v0 = 1; v1 = 1; cdr = 1; d0 = 32'h12345678;
      wait_owner(0, "rst_wait_g0");
      apply();
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_async_grant", 32'(sh.grant), 32'h0);
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      v0 = 0;
      wait_owner(1, "rst_then_r1");
      v1 = 0; fd1 = 1;
      cycle();
      fd1 = 0;
      repeat (3) cycle();

      // randomized traffic, including force_done from the non-owner
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         v0  = ($urandom_range(0, 3) != 0);
         v1  = ($urandom_range(0, 3) != 0);
         fd0 = ($urandom_range(0, 7) == 0);
         fd1 = ($urandom_range(0, 7) == 0);
         dr0 = $urandom_range(0, 1);
         dr1 = $urandom_range(0, 1);
         cdr = $urandom_range(0, 1);
         cdv = $urandom_range(0, 1);
         d0  = $urandom; d1 = $urandom; cd = $urandom;
         cycle();
      end
      check_profile();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
